// File: rtl/mont_result_unloader.sv
// Unloads a Montgomery multiplier result: captures it when done rises, checks it is
// below the modulus word by word from the MSW, then streams it LSW-first over valid/ready.
module mont_result_unloader #(
  parameter int SIZE_INPUT = 2048,
  parameter int WORD_SIZE  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  done_in,
  input  logic [SIZE_INPUT-1:0] result_in,
  input  logic [SIZE_INPUT-1:0] modulus,
  output logic [WORD_SIZE-1:0]  word_out,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  word_last,
  output logic                  range_fault,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int NWORDS = SIZE_INPUT / WORD_SIZE;
  localparam int IDXW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_STREAM,
    ST_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic                    done_q;
  logic [SIZE_INPUT-1:0]   res_q, res_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic                    busy_q, busy_d;
  logic                    fault_q, fault_d;
  logic                    valid_q, valid_d;
  logic [WORD_SIZE-1:0]    wout_q, wout_d;
  logic                    wlast_q, wlast_d;
  logic                    fdone_q, fdone_d;

  logic [WORD_SIZE-1:0]    res_words [NWORDS];
  logic [WORD_SIZE-1:0]    mod_words [NWORDS];
  logic [WORD_SIZE-1:0]    cur_res;
  logic [WORD_SIZE-1:0]    cur_mod;
  logic [IDXW-1:0]         idx_inc;
  logic                    capture;

  // Word views of the captured result and the modulus; all comparisons are per word.
  generate
    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_words
      assign res_words[gi] = res_q[gi*WORD_SIZE +: WORD_SIZE];
      assign mod_words[gi] = modulus[gi*WORD_SIZE +: WORD_SIZE];
    end
  endgenerate

  assign cur_res = res_words[idx_q];
  assign cur_mod = mod_words[idx_q];
  assign idx_inc = idx_q + IDXW'(1);
  assign capture = done_in & ~done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      res_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
      valid_q <= 1'b0;
      wout_q  <= '0;
      wlast_q <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_in;
      res_q   <= res_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
      valid_q <= valid_d;
      wout_q  <= wout_d;
      wlast_q <= wlast_d;
      fdone_q <= fdone_d;
    end
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    fault_d = fault_q;
    valid_d = valid_q;
    wout_d  = wout_q;
    wlast_d = wlast_q;
    fdone_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (capture) begin
          res_d   = result_in;
          idx_d   = LAST_IDX;
          busy_d  = 1'b1;
          fault_d = 1'b0;
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        // Scan from the MSW down; the first unequal word decides, all-equal means not reduced.
        if (cur_res == cur_mod && idx_q != '0) begin
          idx_d = idx_q - IDXW'(1);
        end else begin
          fault_d = (cur_res >= cur_mod);
          state_d = ST_STREAM;
          idx_d   = '0;
          valid_d = 1'b1;
          wout_d  = res_words[0];
          wlast_d = (LAST_IDX == '0);
        end
      end

      ST_STREAM: begin
        if (valid_q && word_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            wout_d  = '0;
            wlast_d = 1'b0;
            busy_d  = 1'b0;
            fdone_d = 1'b1;
          end else begin
            idx_d   = idx_inc;
            wout_d  = res_words[idx_inc];
            wlast_d = (idx_inc == LAST_IDX);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign word_out    = wout_q;
  assign word_valid  = valid_q;
  assign word_last   = wlast_q;
  assign range_fault = fault_q;
  assign busy        = busy_q;
  assign frame_done  = fdone_q;

endmodule

// File: tb/tb_mont_result_unloader.sv
// Bench for mont_result_unloader: per-cycle comparison against a frame-level model,
// plus literal per-frame expectations (check length, stream length, fault, first word).
module tb_mont_result_unloader;

  localparam int SZ = 2048;
  localparam int WS = 64;
  localparam int NW = SZ / WS;

  logic          clk = 1'b0;
  logic          reset;
  logic          done_in;
  logic [SZ-1:0] result_in;
  logic [SZ-1:0] modulus;
  logic [WS-1:0] word_out;
  logic          word_valid;
  logic          word_ready = 1'b0;
  logic          word_last;
  logic          range_fault;
  logic          busy;
  logic          frame_done;

  mont_result_unloader #(.SIZE_INPUT(SZ), .WORD_SIZE(WS)) dut (
    .clk        (clk),
    .reset      (reset),
    .done_in    (done_in),
    .result_in  (result_in),
    .modulus    (modulus),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_last  (word_last),
    .range_fault(range_fault),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  // Literal expectations for the next completed frame (-1 = do not check).
  logic          lit_en = 1'b0;
  int            lit_k = -1;
  int            lit_s = -1;
  int            lit_f = -1;
  logic          lit_w0_en = 1'b0;
  logic [WS-1:0] lit_w0 = '0;

  int ready_mode = 0;

  // ---------------- reference model ----------------
  int            m_mode = 0;     // 0 idle, 1 checking, 2 streaming, 3 done pulse
  int            m_left = 0;
  int            m_sent = 0;
  logic [SZ-1:0] m_res = '0;
  logic          m_fault = 1'b0;
  logic          m_done_prev = 1'b0;
  logic          rise;
  logic [WS-1:0] exp_word = '0;
  logic          exp_valid = 1'b0;
  logic          exp_last = 1'b0;
  logic          exp_fault = 1'b0;
  logic          exp_busy = 1'b0;
  logic          exp_fdone = 1'b0;

  // Check length: one cycle per word from the MSW down to the highest differing word.
  function automatic int check_cycles(input logic [SZ-1:0] r, input logic [SZ-1:0] m);
    for (int w = NW - 1; w >= 0; w--)
      if (r[w*WS +: WS] != m[w*WS +: WS]) return NW - w;
    return NW;
  endfunction

  function automatic logic [WS-1:0] word_of(input logic [SZ-1:0] v, input int i);
    return v[i*WS +: WS];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_done_prev = 1'b0;
      exp_word = '0; exp_valid = 1'b0; exp_last = 1'b0;
      exp_fault = 1'b0; exp_busy = 1'b0; exp_fdone = 1'b0;
    end else begin
      rise = done_in && !m_done_prev;
      m_done_prev = done_in;
      case (m_mode)
        0: if (rise) begin
          m_res     = result_in;
          m_left    = check_cycles(result_in, modulus);
          m_fault   = (result_in >= modulus);
          exp_busy  = 1'b1;
          exp_fault = 1'b0;
          m_mode    = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_mode = 2; m_sent = 0;
            exp_valid = 1'b1; exp_word = word_of(m_res, 0);
            exp_last = 1'b0; exp_fault = m_fault;
          end
        end
        2: if (word_ready) begin
          if (m_sent == NW - 1) begin
            m_mode = 3;
            exp_valid = 1'b0; exp_word = '0; exp_last = 1'b0;
            exp_busy = 1'b0; exp_fdone = 1'b1;
          end else begin
            m_sent++;
            exp_word = word_of(m_res, m_sent);
            exp_last = (m_sent == NW - 1);
          end
        end
        default: begin
          exp_fdone = 1'b0;
          m_mode = 0;
        end
      endcase
    end
  end

  // ---------------- compare process ----------------
  int            k_cnt = 0;
  int            s_cnt = 0;
  int            frames = 0;
  logic [WS-1:0] first_w = '0;
  logic          first_f = 1'b0;

  task automatic chk(input string name, input logic [WS-1:0] act, input logic [WS-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("word_out",    word_out,          exp_word);
      chk("word_valid",  WS'(word_valid),   WS'(exp_valid));
      chk("word_last",   WS'(word_last),    WS'(exp_last));
      chk("range_fault", WS'(range_fault),  WS'(exp_fault));
      chk("busy",        WS'(busy),         WS'(exp_busy));
      chk("frame_done",  WS'(frame_done),   WS'(exp_fdone));
      if (!busy && !frame_done) begin
        k_cnt = 0; s_cnt = 0;
      end else begin
        if (busy && !word_valid) k_cnt++;
        if (word_valid) begin
          if (s_cnt == 0) begin first_w = word_out; first_f = range_fault; end
          s_cnt++;
        end
      end
      if (frame_done) begin
        frames++;
        $display("frame %0d: check_cycles=%0d stream_cycles=%0d fault=%0b word0=%h",
                 frames, k_cnt, s_cnt, first_f, first_w);
        if (lit_en) begin
          if (lit_k >= 0) chk("lit_check_cycles", WS'(k_cnt), WS'(lit_k));
          if (lit_s >= 0) chk("lit_stream_cycles", WS'(s_cnt), WS'(lit_s));
          if (lit_f >= 0) chk("lit_range_fault", WS'(first_f), WS'(lit_f));
          if (lit_w0_en)  chk("lit_word0", first_w, lit_w0);
        end
      end
    end
  end

  // ---------------- ready driver ----------------
  int ph = 0;
  always @(negedge clk) begin
    case (ready_mode)
      0: word_ready = 1'b1;
      1: word_ready = 1'($urandom_range(0, 1));
      default: begin
        if (!word_valid) ph = 0;
        word_ready = (ph % 3 == 2);
        if (word_valid) ph++;
      end
    endcase
  end

  // ---------------- stimulus ----------------
  task automatic wait_frame();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frame_done) return;
    end
    $display("FAIL frame_timeout: got no frame_done expected one within 3000 cycles");
    $fatal(1, "timeout");
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (word_valid) return;
    end
    $display("FAIL valid_timeout: got no word_valid expected one within 200 cycles");
    $fatal(1, "timeout");
  endtask

  task automatic run_frame(input logic [SZ-1:0] r, input logic [SZ-1:0] m,
                           input int lk, input int ls, input int lf,
                           input logic w0en, input logic [WS-1:0] w0);
    result_in = r; modulus = m;
    lit_en = (lk >= 0) || (ls >= 0) || (lf >= 0) || w0en;
    lit_k = lk; lit_s = ls; lit_f = lf; lit_w0_en = w0en; lit_w0 = w0;
    done_in = 1'b1;
    repeat (2) @(negedge clk);
    done_in = 1'b0;
    wait_frame();
    @(negedge clk);
    lit_en = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  logic [SZ-1:0] r, m;

  initial begin
    reset = 1'b1; done_in = 1'b0; result_in = '0; modulus = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic reduced result: full-length check, fault clear
    r = '0; r[63:0] = 64'd5; m = '0; m[63:0] = 64'd7;
    run_frame(r, m, 32, 32, 0, 1'b1, 64'd5);

    // Equal operands: not reduced
    r = '0; r[63:0] = 64'd7;
    run_frame(r, m, 32, 32, 1, 1'b1, 64'd7);

    // Early MSW decision
    r = '0; r[2047:1984] = 64'd2; m = '0; m[2047:1984] = 64'd1;
    run_frame(r, m, 1, 32, 1, 1'b1, 64'd0);

    // Backpressure 0,0,1: each word held three cycles
    for (int i = 0; i < NW; i++) r[i*WS +: WS] = WS'(i + 1);
    m = '1;
    ready_mode = 2;
    run_frame(r, m, 1, 96, 0, 1'b1, 64'd1);
    ready_mode = 0;

    // Retrigger: done held high, extra edge mid-stream, no second frame until it falls
    for (int i = 0; i < NW; i++) r[i*WS +: WS] = WS'(3 * i);
    result_in = r; modulus = m;
    done_in = 1'b1;
    wait_valid();
    repeat (5) @(negedge clk);
    done_in = 1'b0;
    @(negedge clk);
    done_in = 1'b1;
    wait_frame();
    repeat (10) @(negedge clk);
    done_in = 1'b0;
    repeat (2) @(negedge clk);
    lit_en = 1'b1; lit_k = 1; lit_s = 32; lit_f = 0; lit_w0_en = 1'b1; lit_w0 = 64'd0;
    done_in = 1'b1;
    wait_frame();
    @(negedge clk);
    lit_en = 1'b0;
    done_in = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-stream at word 10, then a fresh frame from word 0
    for (int i = 0; i < NW; i++) r[i*WS +: WS] = {$urandom, $urandom};
    m = r; m[SZ-1:SZ-WS] = r[SZ-1:SZ-WS] + 64'd1;
    result_in = r; modulus = m;
    done_in = 1'b1;
    wait_valid();
    repeat (10) @(negedge clk);
    reset = 1'b1; done_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    run_frame(r, m, 1, 32, 0, 1'b1, r[63:0]);

    // Randomized frames with random shared-prefix length and random ready
    ready_mode = 1;
    for (int f = 0; f < 20; f++) begin
      int eq;
      eq = $urandom_range(0, NW);
      for (int i = 0; i < NW; i++) m[i*WS +: WS] = {$urandom, $urandom};
      r = m;
      for (int i = 0; i < NW - eq; i++) begin
        if ($urandom_range(0, 3) == 0) r[i*WS +: WS] = m[i*WS +: WS];
        else r[i*WS +: WS] = {$urandom, $urandom};
      end
      run_frame(r, m, -1, -1, -1, 1'b0, 64'd0);
    end
    ready_mode = 0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mont_result_unloader.md
Name: mont_result_unloader

Overview:
- Sits directly downstream of the 2048-bit Montgomery multiplier.
- Captures the multiplier's full-width result when its done level rises, then checks word-serially that the result is reduced (result < modulus). A result that is not reduced is flagged as a fault.
- Streams the result out, least-significant word first, as 64-bit words on a valid/ready handshake. This is the mirror of the multiplier's 64-bit operand input bus.

Parameters:
- SIZE_INPUT, 2048, operand/result width in bits.
- WORD_SIZE, 64, output word width in bits; SIZE_INPUT must be an integer multiple.
- NWORDS, SIZE_INPUT/WORD_SIZE (32), derived; number of words per frame.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- done_in  input  1  multiplier done level; held high until the multiplier is reset
- result_in  input  SIZE_INPUT  multiplier result, stable while done_in=1
- modulus  input  SIZE_INPUT  modulus N, static during operation
- word_out  output  WORD_SIZE  current output word
- word_valid  output  1  word_out is valid
- word_ready  input  1  consumer accepts word_out
- word_last  output  1  qualifies the final word (index NWORDS-1)
- range_fault  output  1  captured result >= modulus
- busy  output  1  high from capture until the last word is accepted
- frame_done  output  1  one-cycle pulse after the last handshake

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; done_d=0; all outputs 0; word index 0; capture register cleared.
  - Reset asserted in any state aborts the frame immediately; no frame_done is produced.
- Edge detect: done_d<=done_in every cycle. A capture event is done_in & ~done_d.
  - Because done_d resets to 0, a done_in that is already high when reset deasserts counts as one rising edge.
  - Edges that occur while busy=1 are ignored and are not queued.
- States:
  - IDLE: busy=0, word_valid=0. On a capture event: latch result_in into res_q, set idx=NWORDS-1, busy<=1, range_fault<=0, go to CHECK.
  - CHECK: each cycle compare res_q word[idx] with modulus word[idx], unsigned.
    - greater: range_fault<=1, go to STREAM.
    - less: range_fault<=0, go to STREAM.
    - equal and idx>0: idx<=idx-1, stay in CHECK.
    - equal and idx==0: range_fault<=1 (equal to N is not reduced), go to STREAM.
  - CHECK lasts 1..NWORDS cycles.
  - On leaving CHECK, the word index is loaded with 0.
  - STREAM:
    - word_valid=1; word_out=res_q word[idx]; word_last=(idx==NWORDS-1).
    - Handshake when word_valid & word_ready. On a handshake with idx<NWORDS-1, idx<=idx+1. On a handshake with idx==NWORDS-1, go to DONE.
    - Without a handshake, word_out, word_last and idx hold stable (no glitching under backpressure).
    - word_valid must not depend combinationally on word_ready.
  - DONE: one cycle. frame_done=1, busy<=0, word_valid=0, then go to IDLE.
- Output timing and stability:
  - range_fault is valid from the first STREAM cycle and holds until the next capture event or reset.
  - word_out/word_last are registered outputs, driven from res_q and idx.
  - word_out=0 when word_valid=0.
- Latency: capture event at cycle c → first word_valid at cycle c+1+k, where k is the number of CHECK cycles. With word_ready held at 1, the frame spans NWORDS cycles.
- No arithmetic wider than WORD_SIZE. Comparisons are per word only, with no SIZE_INPUT-wide comparator.

Test Plan:
- Basic reduced result, word_ready=1:
  - Stimulus: result_in=5, modulus=7, pulse done_in high.
  - Response: 32 CHECK cycles; range_fault=0; word0=5, words1..31=0; word_last only on word31; frame_done one cycle after word31; busy low afterwards.
- Equal operands:
  - Stimulus: result_in=modulus=7.
  - Response: range_fault=1 after 32 CHECK cycles; all 32 words still streamed.
- Early MSW decision:
  - Stimulus: result_in[2047:1984]=2, modulus[2047:1984]=1.
  - Response: CHECK lasts 1 cycle; range_fault=1; first word_valid 2 cycles after the edge.
- Backpressure:
  - Stimulus: result_in word i = i+1; toggle word_ready 0,0,1 repeatedly.
  - Response: word_out holds each value for 3 cycles; values arrive 1..32 in order; no duplicates or drops; 96 STREAM cycles.
- Retrigger and held done:
  - Stimulus: done_in held high across the entire frame, plus an extra 0→1 transition mid-stream.
  - Response: exactly one frame. After frame_done, a new frame only after done_in falls and rises again.
- Reset mid-stream:
  - Stimulus: assert reset while word_valid=1 at idx=10.
  - Response: next cycle all outputs 0, no frame_done. A subsequent done_in edge starts a fresh frame from word0.
